// File: rtl/violation_reset_ctrl.sv
// violation_reset_ctrl: turns security-monitor violations into a timed system
// reset, then waits for the CPU to reach the reset handler before idling.
//
// Optional feature macro: VIOL_LOG_EN (cause log and sequence counter).
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high block reset
//   pc         - current CPU program counter (16 bits)
//   viol_req   - violation requests: [0] atomicity, [1] key, [2] DMA, [3] irq
//   cause_clr  - single-cycle clear of the cause log
//   sys_rst    - registered system reset, high exactly while in ASSERT
//   busy       - registered, high whenever the controller is not IDLE
//   rst_cause  - sticky OR of violation bits seen (0 without VIOL_LOG_EN)
//   viol_count - saturating count of reset sequences (0 without VIOL_LOG_EN)
module violation_reset_ctrl #(
    parameter int unsigned RST_HOLD      = 4,
    parameter int unsigned WAIT_MAX      = 16,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic [3:0]  viol_req,
    input  logic        cause_clr,
    output logic        sys_rst,
    output logic        busy,
    output logic [3:0]  rst_cause,
    output logic [7:0]  viol_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_HDL = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(RST_HOLD - 1);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] hold;
    logic [3:0] hold_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic       any_viol;
    logic       start;

    assign any_viol = |viol_req;

    // start marks every non-reset entry into ASSERT; it also drives the
    // sequence counter, so entries caused by rst are never counted.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        wait_nxt  = wait_cnt;
        start     = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_viol) begin
                    start = 1'b1;
                end
            end
            ASSERT: begin
                // Violations while asserting neither extend nor recount.
                if (hold == 4'd0) begin
                    state_nxt = WAIT_HDL;
                    wait_nxt  = 8'd0;
                end else begin
                    hold_nxt = hold - 4'd1;
                end
            end
            WAIT_HDL: begin
                // A fresh violation beats a handler match in the same cycle.
                if (any_viol) begin
                    start = 1'b1;
                end else if (pc == RESET_HANDLER) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    start = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (start) begin
            state_nxt = ASSERT;
            hold_nxt  = HOLD_INIT;
            wait_nxt  = 8'd0;
        end
    end

    // sys_rst and busy are registered from the next state so they line up
    // with the state register without a combinational output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ASSERT;
            hold     <= HOLD_INIT;
            wait_cnt <= 8'd0;
            sys_rst  <= 1'b1;
            busy     <= 1'b1;
        end else begin
            state    <= state_nxt;
            hold     <= hold_nxt;
            wait_cnt <= wait_nxt;
            sys_rst  <= (state_nxt == ASSERT);
            busy     <= (state_nxt != IDLE);
        end
    end

`ifdef VIOL_LOG_EN
    logic [3:0] cause_q;
    logic [7:0] count_q;

    // On a clear, the current cycle's requests are kept so nothing is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= 4'd0;
            count_q <= 8'd0;
        end else begin
            if (cause_clr) begin
                cause_q <= viol_req;
            end else begin
                cause_q <= cause_q | viol_req;
            end
            if (start && (count_q != 8'hFF)) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign rst_cause  = cause_q;
    assign viol_count = count_q;
`else
    logic unused_cause_clr;

    assign unused_cause_clr = cause_clr;
    assign rst_cause        = 4'd0;
    assign viol_count       = 8'd0;
`endif

endmodule

// File: doc/violation_reset_ctrl.md
VIOLATION_RESET_CTRL -- requirements
Module: violation_reset_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD, default 4, meaning number of cycles sys_rst is held asserted per violation (legal range 1..15).
REQ-002 SHALL have parameter WAIT_MAX, default 16, meaning maximum cycles allowed after release for pc to reach the reset handler (legal range 1..255).
REQ-003 SHALL have parameter RESET_HANDLER, default 16'hFFFE, meaning the reset vector address fetched after a system reset.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high block reset.
REQ-006 SHALL have port pc, input, 16, current CPU program counter.
REQ-007 SHALL have port viol_req, input, 4, per-monitor violation requests: bit0 atomicity, bit1 key access, bit2 DMA, bit3 interrupt.
REQ-008 SHALL have port cause_clr, input, 1, single-cycle software clear of the cause log.
REQ-009 SHALL have port sys_rst, output, 1, registered system reset to CPU and peripherals.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port rst_cause, output, 4, sticky OR of violation bits seen.
REQ-012 SHALL have port viol_count, output, 8, saturating count of reset sequences started.

Function
REQ-013 SHALL implement the states IDLE, ASSERT and WAIT_HDL; sys_rst SHALL be 1 exactly when the state is ASSERT.
REQ-014 In IDLE with |viol_req=1 at a clock edge, the block SHALL enter ASSERT on that edge, so that sys_rst=1 in the following cycle (1-cycle latency), with the hold counter loaded to RST_HOLD-1.
REQ-015 In ASSERT, the hold counter SHALL decrement each cycle; when the count reaches 0 the block SHALL enter WAIT_HDL, so that sys_rst is high for exactly RST_HOLD cycles, with the wait counter cleared.
REQ-016 viol_req during ASSERT SHALL NOT reload the hold counter and SHALL NOT increment viol_count.
REQ-017 In WAIT_HDL, |viol_req=1 SHALL re-enter ASSERT with the hold counter reloaded and viol_count incremented; this has priority over a pc match.
REQ-018 In WAIT_HDL without a violation, pc==RESET_HANDLER SHALL return the block to IDLE.
REQ-019 In WAIT_HDL, if the wait counter reaches WAIT_MAX-1 without a pc match, the block SHALL re-enter ASSERT and increment viol_count, with rst_cause unchanged.
REQ-020 viol_count SHALL increment by 1 on every entry into ASSERT, except the entry caused by rst, and SHALL saturate at 8'hFF.
REQ-021 rst_cause SHALL OR in viol_req every cycle, in every state.
REQ-022 cause_clr SHALL zero rst_cause; on the same cycle as a nonzero viol_req, rst_cause SHALL equal that cycle's viol_req (new bits win).
REQ-023 busy SHALL be a registered decode of the state, aligned with sys_rst.

Reset
REQ-024 On rst, the block SHALL enter ASSERT with the hold counter at RST_HOLD-1, so that sys_rst=1 and busy=1 in the next cycle, with rst_cause=0 and viol_count=0.
REQ-025 rst SHALL override all other inputs, including rst asserted mid-ASSERT or mid-WAIT_HDL; viol_req in the rst cycle SHALL NOT be logged.
REQ-026 After rst is released, the normal ASSERT -> WAIT_HDL -> IDLE sequence SHALL run.

Configuration
REQ-027 With macro VIOL_LOG_EN defined, rst_cause, viol_count and cause_clr SHALL behave as specified above.
REQ-028 Without VIOL_LOG_EN, rst_cause and viol_count SHALL be tied to 0, cause_clr SHALL be ignored, no logging registers SHALL be synthesized, and the FSM and sys_rst timing SHALL be unchanged.

Verification
REQ-029 rst for 1 cycle, then pc=16'hFFFE -> sys_rst high for 4 cycles, then busy falls 1 cycle after WAIT_HDL is entered, with rst_cause=0 and viol_count=0.
REQ-030 IDLE, viol_req=4'b0001 for 1 cycle -> sys_rst=1 on the next cycle for 4 cycles, rst_cause=4'b0001, viol_count=1.
REQ-031 viol_req=4'b0010 during the 2nd ASSERT cycle -> sys_rst width still 4, rst_cause=4'b0011, viol_count=1.
REQ-032 WAIT_HDL with pc held at 16'hA000 for 16 cycles -> re-ASSERT, sys_rst pulse of 4 cycles, viol_count incremented.
REQ-033 WAIT_HDL, same cycle viol_req=4'b1000 and pc=16'hFFFE -> ASSERT (not IDLE), rst_cause gains bit3.
REQ-034 cause_clr together with viol_req=4'b0100 -> rst_cause=4'b0100; 300 violations -> viol_count=8'hFF; with VIOL_LOG_EN undefined -> both outputs read 0.
